// File: rtl/grid_motion_pkg.sv
// Shared direction encodings and helpers for the grid motion controller.
// Directions are one-hot: bit0 left, bit1 right, bit2 up, bit3 down.
package grid_motion_pkg;

   localparam logic [3:0] DIR_NONE  = 4'b0000;
   localparam logic [3:0] DIR_LEFT  = 4'b0001;
   localparam logic [3:0] DIR_RIGHT = 4'b0010;
   localparam logic [3:0] DIR_UP    = 4'b0100;
   localparam logic [3:0] DIR_DOWN  = 4'b1000;

   typedef enum logic {
      ST_STOPPED,
      ST_MOVING
   } motion_state_e;

   function automatic logic [3:0] opposite_dir(input logic [3:0] d);
      case (d)
         DIR_LEFT:  return DIR_RIGHT;
         DIR_RIGHT: return DIR_LEFT;
         DIR_UP:    return DIR_DOWN;
         DIR_DOWN:  return DIR_UP;
         default:   return DIR_NONE;
      endcase
   endfunction

   function automatic logic is_onehot(input logic [3:0] d);
      return (d != 4'b0000) && ((d & (d - 4'b0001)) == 4'b0000);
   endfunction

endpackage

// File: rtl/motion_tick_div.sv
// Step-rate divider: tick is high during the enabled cycle whose edge ends
// a TICK_DIV-clock period; the count freezes while enable is low.
module motion_tick_div #(
   parameter int TICK_DIV = 524288
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count_q, count_d;

   assign tick = enable && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (enable) begin
         count_d = tick ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/grid_motion_controller.sv
// Tile-grid mover: buffers one-hot direction requests and applies turns,
// continuation and stops on each divided step edge, with a horizontal tunnel wrap.
module grid_motion_controller
   import grid_motion_pkg::*;
#(
   parameter int X_W       = 10,
   parameter int Y_W       = 9,
   parameter int TILE_BITS = 4,
   parameter int TICK_DIV  = 524288,
   parameter int START_X   = 144,
   parameter int START_Y   = 272,
   parameter int X_MAX     = 639
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [3:0]     move_dir,
   input  logic [3:0]     valid_dir,
   input  logic           enable,
   output logic [X_W-1:0] position_x,
   output logic [Y_W-1:0] position_y,
   output logic [3:0]     cur_dir,
   output logic           step_tick
);

   logic [X_W-1:0] pos_x_q, pos_x_d;
   logic [Y_W-1:0] pos_y_q, pos_y_d;
   logic [3:0]     cur_dir_q, cur_dir_d;
   logic [3:0]     buf_dir_q, buf_dir_d;
   logic           step_tick_q;
   logic           tick;
   logic           aligned_x, aligned_y, tile_aligned;
   logic           axis_ok, turn_ok;
   logic [3:0]     go_dir;
   motion_state_e  state;

   motion_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .tick   (tick)
   );

   function automatic logic [X_W-1:0] step_x(input logic [3:0] d, input logic [X_W-1:0] x);
      case (d)
         DIR_LEFT:  return (x == '0) ? X_W'(X_MAX) : x - X_W'(1);
         DIR_RIGHT: return (x == X_W'(X_MAX)) ? '0 : x + X_W'(1);
         default:   return x;
      endcase
   endfunction

   function automatic logic [Y_W-1:0] step_y(input logic [3:0] d, input logic [Y_W-1:0] y);
      case (d)
         DIR_UP:   return y - Y_W'(1);
         DIR_DOWN: return y + Y_W'(1);
         default:  return y;
      endcase
   endfunction

   assign aligned_x    = (pos_x_q[TILE_BITS-1:0] == '0);
   assign aligned_y    = (pos_y_q[TILE_BITS-1:0] == '0);
   assign tile_aligned = aligned_x && aligned_y;
   assign state        = (cur_dir_q == DIR_NONE) ? ST_STOPPED : ST_MOVING;
   // A horizontal turn needs the row centred, a vertical one the column.
   assign axis_ok = ((buf_dir_q & (DIR_LEFT | DIR_RIGHT)) != 4'b0000) ? aligned_y : aligned_x;
   assign turn_ok = (buf_dir_q != DIR_NONE) && axis_ok && tile_aligned &&
                    ((buf_dir_q & valid_dir) != 4'b0000);

   always_comb begin
      cur_dir_d = cur_dir_q;
      buf_dir_d = buf_dir_q;
      go_dir    = DIR_NONE;
      if (tick) begin
         if ((buf_dir_q != DIR_NONE) && (opposite_dir(buf_dir_q) == cur_dir_q)) begin
            cur_dir_d = buf_dir_q;
            buf_dir_d = DIR_NONE;
            go_dir    = buf_dir_q;
         end else if (turn_ok) begin
            cur_dir_d = buf_dir_q;
            buf_dir_d = DIR_NONE;
            go_dir    = buf_dir_q;
         end else if (state == ST_MOVING && !tile_aligned) begin
            go_dir = cur_dir_q;
         end else if (state == ST_MOVING && ((cur_dir_q & valid_dir) != 4'b0000)) begin
            go_dir = cur_dir_q;
         end else if (state == ST_MOVING) begin
            cur_dir_d = DIR_NONE;
         end
      end
      // A fresh request in the same cycle outranks clearing the consumed one.
      if (enable && is_onehot(move_dir)) begin
         buf_dir_d = move_dir;
      end
      pos_x_d = step_x(go_dir, pos_x_q);
      pos_y_d = step_y(go_dir, pos_y_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos_x_q     <= X_W'(START_X);
         pos_y_q     <= Y_W'(START_Y);
         cur_dir_q   <= DIR_NONE;
         buf_dir_q   <= DIR_NONE;
         step_tick_q <= 1'b0;
      end else begin
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         cur_dir_q   <= cur_dir_d;
         buf_dir_q   <= buf_dir_d;
         step_tick_q <= tick;
      end
   end

   assign position_x = pos_x_q;
   assign position_y = pos_y_q;
   assign cur_dir    = cur_dir_q;
   assign step_tick  = step_tick_q;

endmodule

// File: tb/tb_grid_motion_controller.sv
// Directed bench for grid_motion_controller with TICK_DIV=4 and 16-pixel tiles.
module tb_grid_motion_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] move_dir;
   logic [3:0] valid_dir;
   logic       enable;
   logic [9:0] px, wx;
   logic [8:0] py, wy;
   logic [3:0] cd, wd;
   logic       st, wt;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   grid_motion_controller #(
      .X_W(10), .Y_W(9), .TILE_BITS(4), .TICK_DIV(4),
      .START_X(144), .START_Y(272), .X_MAX(639)
   ) dut (
      .clk(clk), .reset(reset), .move_dir(move_dir), .valid_dir(valid_dir),
      .enable(enable), .position_x(px), .position_y(py), .cur_dir(cd), .step_tick(st)
   );

   // Second instance starts at the left tunnel edge.
   grid_motion_controller #(
      .X_W(10), .Y_W(9), .TILE_BITS(4), .TICK_DIV(4),
      .START_X(0), .START_Y(272), .X_MAX(639)
   ) dut_w (
      .clk(clk), .reset(reset), .move_dir(move_dir), .valid_dir(valid_dir),
      .enable(enable), .position_x(wx), .position_y(wy), .cur_dir(wd), .step_tick(wt)
   );

   typedef struct {
      logic [3:0] mv;
      logic [3:0] vd;
      int         ex;
      int         ey;
      logic [3:0] ed;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; move_dir = 4'b0; valid_dir = 4'b0; enable = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] m);
      move_dir = m;
      cyc();
      move_dir = 4'b0;
   endtask

   task automatic wait_step(input string name);
      bit seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         cyc();
         if (st) seen = 1'b1;
      end
      if (!seen) begin
         total++;
         $display("FAIL %s: step_tick never seen within 20 cycles", name);
      end
   endtask

   task automatic go_right_to_150();
      do_reset();
      valid_dir = 4'b0010;
      pulse(4'b0010);
      wait_step("r145");
      valid_dir = 4'b0000;
      for (int i = 0; i < 5; i++) wait_step("r150");
      check("at150_x", px, 150);
   endtask

   initial begin
      vecs[0]  = '{4'b0001, 4'b0001, 143, 272, 4'b0001};
      vecs[1]  = '{4'b0000, 4'b0000, 142, 272, 4'b0001};
      vecs[2]  = '{4'b0010, 4'b0000, 143, 272, 4'b0010};
      vecs[3]  = '{4'b0000, 4'b0000, 144, 272, 4'b0010};
      vecs[4]  = '{4'b0000, 4'b0000, 144, 272, 4'b0000};
      vecs[5]  = '{4'b0011, 4'b1111, 144, 272, 4'b0000};
      vecs[6]  = '{4'b0100, 4'b0100, 144, 271, 4'b0100};
      vecs[7]  = '{4'b0000, 4'b0000, 144, 270, 4'b0100};
      vecs[8]  = '{4'b0001, 4'b1111, 144, 269, 4'b0100};
      vecs[9]  = '{4'b1000, 4'b0000, 144, 270, 4'b1000};
      vecs[10] = '{4'b0000, 4'b0000, 144, 271, 4'b1000};
      vecs[11] = '{4'b0000, 4'b0000, 144, 272, 4'b1000};
      vecs[12] = '{4'b0000, 4'b1000, 144, 273, 4'b1000};
      vecs[13] = '{4'b0000, 4'b0000, 144, 274, 4'b1000};

      do_reset();
      check("rst_x", px, 144);
      check("rst_y", py, 272);
      check("rst_dir", cd, 0);
      check("rst_tick", st, 0);

      for (int i = 0; i < 14; i++) begin
         valid_dir = vecs[i].vd;
         pulse(vecs[i].mv);
         wait_step($sformatf("vec%0d", i));
         check($sformatf("vec%0d_x", i), px, vecs[i].ex);
         check($sformatf("vec%0d_y", i), py, vecs[i].ey);
         check($sformatf("vec%0d_dir", i), cd, vecs[i].ed);
      end

      // Held up request while moving right: turn happens at the next tile centre.
      go_right_to_150();
      valid_dir = 4'b1111;
      move_dir  = 4'b0100;
      for (int i = 0; i < 10; i++) wait_step("hold_up");
      check("hold_up_x160", px, 160);
      check("hold_up_dir_r", cd, 4'b0010);
      wait_step("hold_up_turn");
      check("hold_up_turn_x", px, 160);
      check("hold_up_turn_y", py, 271);
      check("hold_up_turn_dir", cd, 4'b0100);
      move_dir = 4'b0000;

      // Reversal mid-tile.
      go_right_to_150();
      pulse(4'b0001);
      wait_step("reverse");
      check("reverse_x", px, 149);
      check("reverse_dir", cd, 4'b0001);

      // Blocked at tile centre.
      go_right_to_150();
      valid_dir = 4'b0001;
      for (int i = 0; i < 11; i++) wait_step("block");
      check("block_x", px, 160);
      check("block_dir", cd, 4'b0000);
      cyc();
      check("tick_one_cycle", st, 0);
      wait_step("block_hold");
      check("block_hold_x", px, 160);

      // Tunnel wrap, enable freeze, and right-side wrap.
      do_reset();
      valid_dir = 4'b0001;
      pulse(4'b0001);
      wait_step("wrap_l");
      check("wrap_l_x", wx, 639);
      check("wrap_l_dir", wd, 4'b0001);
      cyc(); cyc();
      enable = 1'b0;
      begin
         int ticks_seen = 0;
         for (int i = 0; i < 10; i++) begin
            cyc();
            if (wt) ticks_seen++;
         end
         check("freeze_ticks", ticks_seen, 0);
      end
      check("freeze_x", wx, 639);
      enable = 1'b1;
      cyc();
      check("resume_no_tick", wt, 0);
      cyc();
      check("resume_tick", wt, 1);
      check("resume_x", wx, 638);
      pulse(4'b0010);
      wait_step("wrap_rev");
      check("wrap_rev_x", wx, 639);
      check("wrap_rev_dir", wd, 4'b0010);
      wait_step("wrap_r");
      check("wrap_r_x", wx, 0);

      // Reset coincident with a step edge.
      do_reset();
      valid_dir = 4'b0001;
      pulse(4'b0001);
      wait_step("pre_rst");
      check("pre_rst_x", px, 143);
      cyc(); cyc(); cyc();
      reset = 1'b1;
      cyc();
      check("rst_edge_x", px, 144);
      check("rst_edge_dir", cd, 0);
      check("rst_edge_tick", st, 0);
      reset = 1'b0;
      cyc();
      check("rst_edge_tick2", st, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/grid_motion_controller.md
GRID_MOTION_CONTROLLER -- requirements
Module: grid_motion_controller

Interface
REQ-001 SHALL have parameter X_W, default 10, position_x width.
REQ-002 SHALL have parameter Y_W, default 9, position_y width.
REQ-003 SHALL have parameter TILE_BITS, default 4, log2 of tile size in pixels.
REQ-004 SHALL have parameter TICK_DIV, default 524288, clocks per movement step (>=2).
REQ-005 SHALL have parameter START_X, default 144, reset x.
REQ-006 SHALL have parameter START_Y, default 272, reset y.
REQ-007 SHALL have parameter X_MAX, default 639, highest legal x; tunnel wrap point.
REQ-008 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-009 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-010 SHALL have port move_dir, input, 4, one-hot request: bit0 left, bit1 right, bit2 up, bit3 down; 0 = none.
REQ-011 SHALL have port valid_dir, input, 4, open-path mask for the current tile, same bit order.
REQ-012 SHALL have port enable, input, 1, low freezes position, tick counter and state.
REQ-013 SHALL have port position_x, output, X_W, registered x pixel.
REQ-014 SHALL have port position_y, output, Y_W, registered y pixel.
REQ-015 SHALL have port cur_dir, output, 4, registered one-hot active direction; 0 = stopped.
REQ-016 SHALL have port step_tick, output, 1, registered pulse, high one cycle after each step edge.

Function
REQ-017 Tick counter SHALL count 0..TICK_DIV-1 when enable; "step edge" = the clock edge where count == TICK_DIV-1; count then returns to 0.
REQ-018 Positions and cur_dir SHALL change only on step edges.
REQ-019 Any cycle with move_dir exactly one-hot SHALL load buf_dir; zero or multi-hot move_dir SHALL leave buf_dir unchanged.
REQ-020 aligned_x = position_x[TILE_BITS-1:0]==0; aligned_y likewise; tile_aligned = both.
REQ-021 States: STOPPED (cur_dir==0), MOVING (cur_dir!=0).
REQ-022 Step edge, buf_dir opposite to cur_dir: cur_dir<=buf_dir, buf_dir cleared, one pixel moved in new direction, regardless of alignment.
REQ-023 Step edge, buf_dir left/right with aligned_y (or up/down with aligned_x), tile_aligned, and buf_dir & valid_dir != 0: cur_dir<=buf_dir, buf_dir cleared, one pixel moved.
REQ-024 Else, MOVING and not tile_aligned: continue one pixel in cur_dir; valid_dir ignored.
REQ-025 Else, MOVING, tile_aligned, cur_dir & valid_dir != 0: continue one pixel.
REQ-026 Else, MOVING, tile_aligned, cur_dir blocked: cur_dir<=0 (STOPPED), position held, buf_dir retained.
REQ-027 STOPPED with no acceptable buf_dir: hold position.
REQ-028 x step left at 0 SHALL wrap to X_MAX; right at X_MAX SHALL wrap to 0; y SHALL be modulo 2^Y_W (walls prevent reaching bounds).
REQ-029 Request rules (REQ-022..027) SHALL be evaluated in listed priority order.
REQ-030 step_tick SHALL be 1 exactly in the cycle after a step edge, otherwise 0.

Reset
REQ-031 On reset: position_x=START_X, position_y=START_Y, cur_dir=0, buf_dir=0, count=0, step_tick=0; reset SHALL override enable and win over a coincident step edge.

Structure
REQ-032 Package grid_motion_pkg SHALL hold DIR_LEFT/RIGHT/UP/DOWN/NONE encodings and the opposite-direction helper.
REQ-033 Tick counter SHALL be sub-module motion_tick_div (params TICK_DIV; ports clk, reset, enable, tick).

Verification (TILE_BITS=4, TICK_DIV=4, START 144,272)
REQ-034 Reset, move_dir=0001, valid_dir=0001 -> x 143 after first step edge, cur_dir=0001, step_tick pulse next cycle.
REQ-035 Moving right at x=150, hold move_dir=0100, valid_dir=1111 -> x advances to 160, then y decrements; cur_dir=0100.
REQ-036 Moving right at x=150, pulse move_dir=0001 one cycle -> next step edge x=149, cur_dir=0001.
REQ-037 Moving right to x=160 with valid_dir=0001 -> cur_dir=0000, x stays 160 on later edges.
REQ-038 Force x=0 moving left, valid_dir=0001 -> x=639; enable=0 mid-run -> position and count frozen.
REQ-039 Assert reset coincident with step edge -> outputs equal reset values next cycle.
